mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mips_pkg.sv | 16 +
 rtl/mem_arb_timer.sv | 28 ++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mips_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IBUSY = 2'd1,
        ARB_DBUSY = 2'd2,
        ARB_DONE  = 2'd3
    } arb_state_e;

    localparam int TIMEOUT_DEFAULT = 16;

    localparam logic GRANT_INSTR = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the memory arbiter; flags expiry when the count reaches TIMEOUT-1.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access,
// with a timeout that turns an unanswered request into an error completion.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        err
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic busy;
    logic tmr_expired;

    assign busy = (state_q == ARB_IBUSY) || (state_q == ARB_DBUSY);

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == ARB_IDLE),
        .enable (busy && !m_ack && !tmr_expired),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ARB_IDLE: begin
                // Contention goes to whichever side did not win last time.
                if (d_req && (!i_req || last_grant_q == GRANT_INSTR)) begin
                    state_d      = ARB_DBUSY;
                    last_grant_d = GRANT_DATA;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    we_d         = d_we;
                    err_d        = 1'b0;
                end else if (i_req) begin
                    state_d      = ARB_IBUSY;
                    last_grant_d = GRANT_INSTR;
                    addr_d       = i_addr;
                    wdata_d      = '0;
                    we_d         = 1'b0;
                    err_d        = 1'b0;
                end
            end
            ARB_IBUSY, ARB_DBUSY: begin
                // An ack arriving on the expiry cycle still counts as a good completion.
                if (m_ack || tmr_expired) begin
                    state_d = ARB_DONE;
                    err_d   = !m_ack;
                    if (!we_q) begin
                        if (state_q == ARB_IBUSY) begin
                            i_rdata_d = m_ack ? m_rdata : '0;
                        end else begin
                            d_rdata_d = m_ack ? m_rdata : '0;
                        end
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_INSTR;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign m_req   = busy;
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = (state_q == ARB_DONE) && (last_grant_q == GRANT_INSTR);
    assign d_ready = (state_q == ARB_DONE) && (last_grant_q == GRANT_DATA);
    assign err     = (state_q == ARB_DONE) && err_q;

endmodule
